// File: rtl/serial_shift_pkg.sv
// Shared types and default sizing for the serial_shift_out display-chain driver.
package serial_shift_pkg;

   localparam int unsigned DEFAULT_DATA_W  = 64;
   localparam int unsigned DEFAULT_CLK_DIV = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

endpackage

// File: rtl/clk_tick_div.sv
// Free-running divider: tick is high on the last of every CLK_DIV cycles; clr restarts the count.
module clk_tick_div
   import serial_shift_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int unsigned      DIV_W = $clog2(CLK_DIV + 1);
   localparam logic [DIV_W-1:0] LAST  = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_nxt;
   logic             tick_nxt;

   // tick is registered and always equals (cnt == LAST)
   always_comb begin
      cnt_nxt = cnt + DIV_W'(1);
      if (clr || (cnt == LAST)) begin
         cnt_nxt = '0;
      end
      tick_nxt = (cnt_nxt == LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         tick <= tick_nxt;
      end
   end

endmodule

// File: rtl/serial_shift_out.sv
// Serialises one accepted parallel word onto an sclk/sdata/latch shift chain.
// Build option SERIAL_SHIFT_OUT_LSB_FIRST_EN sends bit 0 first instead of the MSB.
module serial_shift_out
   import serial_shift_pkg::*;
#(
   parameter int unsigned DATA_W  = DEFAULT_DATA_W,
   parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              sclk,
   output logic              sdata,
   output logic              latch,
   output logic              busy,
   output logic              done
);

   localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_nxt;
   logic [DATA_W-1:0] shreg_shifted;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  bit_cnt_nxt;
   logic              sclk_nxt;
   logic              latch_nxt;
   logic              busy_nxt;
   logic              ready_nxt;
   logic              done_nxt;
   logic              clr_c;
   logic              tick;

   clk_tick_div #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_c),
      .tick  (tick)
   );

`ifdef SERIAL_SHIFT_OUT_LSB_FIRST_EN
   assign shreg_shifted = {1'b0, shreg[DATA_W-1:1]};
   assign sdata         = shreg[0];
`else
   assign shreg_shifted = {shreg[DATA_W-2:0], 1'b0};
   assign sdata         = shreg[DATA_W-1];
`endif

   // Next state and next values of every registered output
   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      sclk_nxt    = sclk;
      done_nxt    = 1'b0;
      clr_c       = 1'b0;

      case (state)
         IDLE: begin
            sclk_nxt = 1'b0;
            if (din_valid && din_ready) begin
               shreg_nxt   = din;
               bit_cnt_nxt = '0;
               clr_c       = 1'b1;
               state_nxt   = SHIFT;
            end
         end
         SHIFT: begin
            if (tick) begin
               sclk_nxt = ~sclk;
               // data advances only on the falling sclk transition
               if (sclk) begin
                  shreg_nxt   = shreg_shifted;
                  bit_cnt_nxt = bit_cnt + CNT_W'(1);
                  if (bit_cnt == LAST_BIT) begin
                     clr_c     = 1'b1;
                     state_nxt = LATCH;
                  end
               end
            end
         end
         LATCH: begin
            sclk_nxt = 1'b0;
            if (tick) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            sclk_nxt  = 1'b0;
            state_nxt = IDLE;
         end
      endcase

      latch_nxt = (state_nxt == LATCH);
      busy_nxt  = (state_nxt != IDLE);
      ready_nxt = (state_nxt == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         sclk      <= 1'b0;
         latch     <= 1'b0;
         busy      <= 1'b0;
         din_ready <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         shreg     <= shreg_nxt;
         bit_cnt   <= bit_cnt_nxt;
         sclk      <= sclk_nxt;
         latch     <= latch_nxt;
         busy      <= busy_nxt;
         din_ready <= ready_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_serial_shift_out.sv
// Directed self-checking bench for serial_shift_out (8-bit/div-2 and 4-bit/div-1 instances).
module tb_serial_shift_out;

   logic       clk = 1'b0;
   logic       rst_n;

   logic [7:0] din;
   logic       din_valid;
   logic       din_ready, sclk, sdata, latch, busy, done;

   logic [3:0] din_m;
   logic       din_valid_m;
   logic       din_ready_m, sclk_m, sdata_m, latch_m, busy_m, done_m;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_shift_out #(.DATA_W(8), .CLK_DIV(2)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .sclk(sclk), .sdata(sdata), .latch(latch), .busy(busy), .done(done));

   serial_shift_out #(.DATA_W(4), .CLK_DIV(1)) dut_min (
      .clk(clk), .rst_n(rst_n), .din(din_m), .din_valid(din_valid_m), .din_ready(din_ready_m),
      .sclk(sclk_m), .sdata(sdata_m), .latch(latch_m), .busy(busy_m), .done(done_m));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Follows one 8-bit frame from just after its accept edge until done (bounded)
   task automatic mon8(output logic [7:0] bits, output int lat, output int nrise,
                       output int latch_hi, output int viol);
      logic prev;
      prev = 1'b0; bits = '0; lat = 0; nrise = 0; latch_hi = 0; viol = 0;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         if (sclk && !prev) begin
            bits = {bits[6:0], sdata};
            nrise++;
         end
         prev = sclk;
         if (latch) latch_hi++;
         if (din_ready && busy) viol++;
         if (latch && sclk) viol++;
         if (done) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic start8(input logic [7:0] w);
      @(negedge clk);
      check("ready_before_accept", 64'(din_ready), 64'd1);
      din = w; din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0;
      din = ~w;
   endtask

   logic [7:0] bits;
   logic [3:0] bits4;
   int         lat, nrise, latch_hi, viol, toggles;
   logic       prev;

   initial begin
      rst_n = 1'b1;
      din = '0; din_valid = 1'b0; din_m = '0; din_valid_m = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_sclk",  64'(sclk),  64'd0);
      check("rst_sdata", 64'(sdata), 64'd0);
      check("rst_latch", 64'(latch), 64'd0);
      check("rst_busy",  64'(busy),  64'd0);
      check("rst_done",  64'(done),  64'd0);
      check("rst_ready", 64'(din_ready), 64'd0);
      check("rst_ready_m", 64'(din_ready_m), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_release", 64'(din_ready), 64'd1);
      check("ready_after_release_m", 64'(din_ready_m), 64'd1);

      // Basic frame A5
      start8(8'hA5);
      check("busy_after_accept", 64'(busy), 64'd1);
      mon8(bits, lat, nrise, latch_hi, viol);
      check("a5_bits", 64'(bits), 64'hA5);
      check("a5_rises", 64'(nrise), 64'd8);
      check("a5_latency", 64'(lat), 64'd34);
      check("a5_latch_cycles", 64'(latch_hi), 64'd2);
      check("a5_viol", 64'(viol), 64'd0);

      // Backpressure: 3C held valid during the A5 frame, taken in the done cycle
      @(negedge clk);
      din = 8'hA5; din_valid = 1'b1;
      @(posedge clk); #1;
      din = 8'h3C;
      mon8(bits, lat, nrise, latch_hi, viol);
      check("bp_first_bits", 64'(bits), 64'hA5);
      check("bp_first_latency", 64'(lat), 64'd34);
      check("bp_no_ready_while_busy", 64'(viol), 64'd0);
      check("bp_ready_in_done", 64'(din_ready), 64'd1);
      @(posedge clk); #1;
      din_valid = 1'b0;
      check("bp_second_busy", 64'(busy), 64'd1);
      mon8(bits, lat, nrise, latch_hi, viol);
      check("bp_second_bits", 64'(bits), 64'h3C);
      check("bp_second_latency", 64'(lat), 64'd34);

      // Send order distinguished by a non-palindromic word
      start8(8'h01);
      mon8(bits, lat, nrise, latch_hi, viol);
`ifdef SERIAL_SHIFT_OUT_LSB_FIRST_EN
      check("w01_bits", 64'(bits), 64'h80);
`else
      check("w01_bits", 64'(bits), 64'h01);
`endif
      check("w01_latency", 64'(lat), 64'd34);

      // Minimum divider on the 4-bit instance
      @(negedge clk);
      check("min_ready", 64'(din_ready_m), 64'd1);
      din_m = 4'b1001; din_valid_m = 1'b1;
      @(posedge clk); #1;
      din_valid_m = 1'b0;
      prev = 1'b0; bits4 = '0; nrise = 0; latch_hi = 0; lat = 0; toggles = 0;
      for (int c = 1; c <= 50; c++) begin
         @(posedge clk); #1;
         if (sclk_m != prev) toggles++;
         if (sclk_m && !prev) begin
            bits4 = {bits4[2:0], sdata_m};
            nrise++;
         end
         prev = sclk_m;
         if (latch_m) latch_hi++;
         if (done_m) begin
            lat = c;
            break;
         end
      end
      check("min_bits", 64'(bits4), 64'h9);
      check("min_rises", 64'(nrise), 64'd4);
      check("min_toggles", 64'(toggles), 64'd8);
      check("min_latch_cycles", 64'(latch_hi), 64'd1);
      check("min_latency", 64'(lat), 64'd9);

      // Reset after the third sclk rise of an FF frame
      start8(8'hFF);
      prev = 1'b0; nrise = 0;
      for (int c = 0; c < 100 && nrise < 3; c++) begin
         @(posedge clk); #1;
         if (sclk && !prev) nrise++;
         prev = sclk;
      end
      check("mid_rises_seen", 64'(nrise), 64'd3);
      #2 rst_n = 1'b0;
      #1;
      check("mid_sclk",  64'(sclk),  64'd0);
      check("mid_sdata", 64'(sdata), 64'd0);
      check("mid_latch", 64'(latch), 64'd0);
      check("mid_busy",  64'(busy),  64'd0);
      check("mid_ready", 64'(din_ready), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      latch_hi = 0; viol = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (latch) latch_hi++;
         if (done || busy) viol++;
      end
      check("post_rst_ready", 64'(din_ready), 64'd1);
      check("post_rst_no_latch", 64'(latch_hi), 64'd0);
      check("post_rst_no_done", 64'(viol), 64'd0);
      start8(8'h81);
      mon8(bits, lat, nrise, latch_hi, viol);
      check("w81_bits", 64'(bits), 64'h81);
      check("w81_latency", 64'(lat), 64'd34);
      check("w81_latch_cycles", 64'(latch_hi), 64'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
